// File: rtl/biu_mux_bus.sv
// Multiplexed address/data bus interface unit: turns a single request into an
// ALE-qualified address phase followed by a data phase with bounded slave wait.
module biu_mux_bus #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int WAIT_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] o_Address_Data_Bus,
    output logic              bus_oe,
    output logic              ALE,
    output logic              W_R,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_rdy,
    output logic [7:0]        err_cnt,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, nothing queues.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        write_d            = write_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        cnt_d              = cnt_q;
        err_d              = err_q;
        rdata_d            = rdata_q;
        err_cnt_d          = err_cnt_q;
        req_ready          = 1'b0;
        rsp_valid          = 1'b0;
        rsp_err            = 1'b0;
        ALE                = 1'b0;
        bus_oe             = 1'b0;
        o_Address_Data_Bus = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                ALE                = 1'b1;
                bus_oe             = 1'b1;
                o_Address_Data_Bus = DATA_W'(addr_q);
                cnt_d              = '0;
                state_d            = DATA;
            end
            DATA: begin
                if (write_q) begin
                    bus_oe             = 1'b1;
                    o_Address_Data_Bus = wdata_q;
                end
                // Ready is checked before the limit so a late ready still succeeds.
                if (i_bus_rdy) begin
                    if (!write_q) rdata_d = i_bus_data;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == WAIT_LIM) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign W_R         = write_q;
    assign rsp_rdata   = rdata_q;
    assign err_cnt     = err_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_biu_mux_bus.sv
// Directed bench for biu_mux_bus: address/data phasing, waits, timeouts,
// back-to-back requests, reset abort and error-counter saturation.
module tb_biu_mux_bus;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] bus;
    logic       bus_oe;
    logic       ale;
    logic       w_r;
    logic [7:0] i_bus_data;
    logic       i_bus_rdy;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    biu_mux_bus #(.DATA_W(8), .ADDR_W(8), .WAIT_MAX(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .o_Address_Data_Bus (bus),
        .bus_oe             (bus_oe),
        .ALE                (ale),
        .W_R                (w_r),
        .i_bus_data         (i_bus_data),
        .i_bus_rdy          (i_bus_rdy),
        .err_cnt            (err_cnt),
        .dbg_state_o        (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, dbg_state, S_IDLE);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_rspv"}, rsp_valid, 0);
        chk({tag, "_rspe"}, rsp_err, 0);
        chk({tag, "_bus"}, bus, 0);
        chk({tag, "_oe"}, bus_oe, 0);
        chk({tag, "_ale"}, ale, 0);
    endtask

    // One read that never sees ready; returns with the DUT back in IDLE.
    task automatic do_timeout();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h55;
        i_bus_rdy = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        chk("sat_rspv", rsp_valid, 1);
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 8'hAA;
        req_wdata  = 8'hBB;
        i_bus_data = 8'h00;
        i_bus_rdy  = 1'b0;
        tick();
        tick();
        // Request present during reset must not be taken.
        chk_idle_outputs("rst");
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_wr", w_r, 0);
        chk("rst_errcnt", err_cnt, 0);
        reset     = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("rst_stay_idle", dbg_state, S_IDLE);

        // Write 0x06 to 0x07, slave always ready.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 8'h06;
        i_bus_rdy = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("wr_a_state", dbg_state, S_ADDR);
        chk("wr_a_ale", ale, 1);
        chk("wr_a_oe", bus_oe, 1);
        chk("wr_a_bus", bus, 8'h07);
        chk("wr_a_wr", w_r, 1);
        chk("wr_a_ready", req_ready, 0);
        tick();
        chk("wr_d_state", dbg_state, S_DATA);
        chk("wr_d_ale", ale, 0);
        chk("wr_d_oe", bus_oe, 1);
        chk("wr_d_bus", bus, 8'h06);
        chk("wr_d_wr", w_r, 1);
        chk("wr_d_rspv", rsp_valid, 0);
        tick();
        chk("wr_done_rspv", rsp_valid, 1);
        chk("wr_done_err", rsp_err, 0);
        chk("wr_done_oe", bus_oe, 0);
        chk("wr_done_wr", w_r, 1);
        tick();
        chk_idle_outputs("wr_idle");
        chk("wr_idle_wr_hold", w_r, 1);

        // Read from 0x02 with two wait cycles.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h02;
        i_bus_rdy = 1'b0; i_bus_data = 8'hA5;
        tick();
        req_valid = 1'b0;
        chk("rd_a_bus", bus, 8'h02);
        chk("rd_a_wr", w_r, 0);
        tick();
        chk("rd_d1_state", dbg_state, S_DATA);
        chk("rd_d1_oe", bus_oe, 0);
        chk("rd_d1_bus", bus, 0);
        tick();
        chk("rd_d2_state", dbg_state, S_DATA);
        tick();
        chk("rd_d3_state", dbg_state, S_DATA);
        chk("rd_d3_rspv", rsp_valid, 0);
        i_bus_rdy = 1'b1;
        tick();
        chk("rd_done_rspv", rsp_valid, 1);
        chk("rd_done_rdata", rsp_rdata, 8'hA5);
        chk("rd_done_err", rsp_err, 0);
        i_bus_data = 8'h11;
        tick();
        chk("rd_idle_rspv", rsp_valid, 0);
        chk("rd_rdata_hold", rsp_rdata, 8'hA5);

        // Read with slave never ready: four DATA cycles, then timeout.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
        i_bus_rdy = 1'b0; i_bus_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_in_data", dbg_state, S_DATA);
            chk("to_no_rspv", rsp_valid, 0);
        end
        tick();
        chk("to_rspv", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        tick();
        chk("to_errcnt", err_cnt, 1);
        chk("to_idle_err", rsp_err, 0);

        // Ready arriving on the last allowed DATA cycle wins over timeout.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20;
        i_bus_rdy = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("late_in_data", dbg_state, S_DATA);
        i_bus_rdy = 1'b1; i_bus_data = 8'h5A;
        tick();
        chk("late_rspv", rsp_valid, 1);
        chk("late_err", rsp_err, 0);
        chk("late_rdata", rsp_rdata, 8'h5A);
        tick();
        chk("late_errcnt", err_cnt, 1);

        // req_valid held high: second acceptance only from IDLE, 4 cycles later.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 8'h44;
        i_bus_rdy = 1'b1;
        tick();
        chk("b2b_a_ready", req_ready, 0);
        chk("b2b_a_state", dbg_state, S_ADDR);
        tick();
        chk("b2b_d_ready", req_ready, 0);
        chk("b2b_d_bus", bus, 8'h44);
        tick();
        chk("b2b_done_ready", req_ready, 0);
        chk("b2b_done_rspv", rsp_valid, 1);
        req_addr = 8'h34;
        tick();
        chk("b2b_idle_ready", req_ready, 1);
        chk("b2b_idle_state", dbg_state, S_IDLE);
        tick();
        chk("b2b_2nd_state", dbg_state, S_ADDR);
        chk("b2b_2nd_bus", bus, 8'h34);
        chk("b2b_2nd_ale", ale, 1);
        req_valid = 1'b0;
        tick(); tick(); tick();
        chk("b2b_end_state", dbg_state, S_IDLE);

        // Reset during DATA of a stalled write aborts without a response.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h66; req_wdata = 8'h77;
        i_bus_rdy = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstd_in_data", dbg_state, S_DATA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_outputs("rstd");
        chk("rstd_wr", w_r, 0);
        chk("rstd_errcnt", err_cnt, 0);
        chk("rstd_rdata", rsp_rdata, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstd_no_rspv", rsp_valid, 0);
        end

        // Error counter saturation.
        for (int i = 0; i < 255; i++) do_timeout();
        chk("sat_255", err_cnt, 8'd255);
        do_timeout();
        do_timeout();
        chk("sat_hold", err_cnt, 8'd255);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sat_rst", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
